// File: rtl/load_store_unit_if.sv
// Request/response and word-memory bus of the load/store unit.
// Handshake: a request transfers on the rising edge where req_valid && req_ready are both high;
// the requester holds every req_* field stable while req_valid is high, and resp_valid is a one-cycle pulse.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_addr;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    // Requester plus the memory it owns.
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error, mem_addr, mem_write_enable, mem_write_data
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error, mem_addr, mem_write_enable, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32 byte-addressed load/store unit in front of a word-wide memory with combinational read.
// Sub-word stores are read-modify-write; word-crossing accesses take two word cycles (or error out).
module load_store_unit #(
    parameter bit MISALIGNED_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_W0   = 3'd1,
        S_W1   = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t      state, state_nxt;

    logic        l_write;
    logic        l_unsigned;
    logic [1:0]  l_size;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [31:0] lo, hi;

    logic        resp_valid_q;
    logic        resp_error_q;
    logic [31:0] resp_rdata_q;

    logic [1:0]  l_off;
    logic [29:0] l_idx;
    logic [3:0]  l_mask;
    logic        l_split;
    logic        req_split;
    logic [63:0] st_lanes;
    logic [7:0]  st_mask;
    logic [31:0] merge_lo, merge_hi;
    logic [31:0] ld_win;
    logic [31:0] ld_data;

    logic        req_ready_c;
    logic [31:0] mem_addr_c;
    logic        mem_we_c;
    logic [31:0] mem_wdata_c;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic crosses_word(input logic [1:0] off, input logic [1:0] sz);
        logic [2:0] end_lane;
        end_lane = {1'b0, off} + size_bytes(sz);
        return end_lane > 3'd4;
    endfunction

    always_comb begin
        l_off     = l_addr[1:0];
        l_idx     = l_addr[31:2];
        l_split   = crosses_word(l_off, l_size);
        req_split = crosses_word(bus.req_addr[1:0], bus.req_size);
        case (l_size)
            2'b00:   l_mask = 4'b0001;
            2'b01:   l_mask = 4'b0011;
            default: l_mask = 4'b1111;
        endcase
        // Store data and byte mask laid out across the two words an access can touch.
        st_lanes = {32'd0, l_wdata} << {l_off, 3'b000};
        st_mask  = {4'd0, l_mask} << l_off;
        merge_lo = bus.mem_read_data;
        merge_hi = bus.mem_read_data;
        for (int i = 0; i < 4; i++) begin
            if (st_mask[i])   merge_lo[8*i +: 8] = st_lanes[8*i +: 8];
            if (st_mask[i+4]) merge_hi[8*i +: 8] = st_lanes[32 + 8*i +: 8];
        end
        ld_win = 32'({hi, lo} >> {l_off, 3'b000});
        case (l_size)
            2'b00:   ld_data = {{24{~l_unsigned & ld_win[7]}}, ld_win[7:0]};
            2'b01:   ld_data = {{16{~l_unsigned & ld_win[15]}}, ld_win[15:0]};
            default: ld_data = ld_win;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        req_ready_c = 1'b0;
        mem_addr_c  = 32'd0;
        mem_we_c    = 1'b0;
        mem_wdata_c = 32'd0;
        case (state)
            S_IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    if (req_split && (MISALIGNED_EN == 1'b0)) state_nxt = S_ERR;
                    else                                      state_nxt = S_W0;
                end
            end
            S_W0: begin
                mem_addr_c = {2'b00, l_idx};
                if (l_write) begin
                    mem_we_c    = 1'b1;
                    mem_wdata_c = merge_lo;
                end
                state_nxt = l_split ? S_W1 : S_DONE;
            end
            S_W1: begin
                // Word index wraps modulo 2^30, so the top word continues at word 0.
                mem_addr_c = {2'b00, l_idx + 30'd1};
                if (l_write) begin
                    mem_we_c    = 1'b1;
                    mem_wdata_c = merge_hi;
                end
                state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // A reset edge must never commit a write, including the second half of a split store.
        if (reset) mem_we_c = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            l_write      <= 1'b0;
            l_unsigned   <= 1'b0;
            l_size       <= 2'b00;
            l_addr       <= 32'd0;
            l_wdata      <= 32'd0;
            lo           <= 32'd0;
            hi           <= 32'd0;
        end else begin
            state        <= state_nxt;
            resp_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        l_write    <= bus.req_write;
                        l_unsigned <= bus.req_unsigned;
                        l_size     <= bus.req_size;
                        l_addr     <= bus.req_addr;
                        l_wdata    <= bus.req_wdata;
                    end
                end
                S_W0: if (!l_write) lo <= bus.mem_read_data;
                S_W1: if (!l_write) hi <= bus.mem_read_data;
                S_DONE: begin
                    resp_valid_q <= 1'b1;
                    resp_error_q <= 1'b0;
                    resp_rdata_q <= l_write ? 32'd0 : ld_data;
                end
                S_ERR: begin
                    resp_valid_q <= 1'b1;
                    resp_error_q <= 1'b1;
                    resp_rdata_q <= 32'd0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready        = req_ready_c;
    assign bus.mem_addr         = mem_addr_c;
    assign bus.mem_write_enable = mem_we_c;
    assign bus.mem_write_data   = mem_wdata_c;
    assign bus.resp_valid       = resp_valid_q;
    assign bus.resp_error       = resp_error_q;
    assign bus.resp_rdata       = resp_rdata_q;
    assign dbg_state            = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: one instance with misaligned splitting, one that rejects misaligned
// accesses, each on a 16-word memory; results are compared with a byte-level reference model.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if bus_a ();
    load_store_unit_if bus_b ();
    logic [2:0] dbg_a, dbg_b;

    load_store_unit #(.MISALIGNED_EN(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave), .dbg_state(dbg_a));
    load_store_unit #(.MISALIGNED_EN(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave), .dbg_state(dbg_b));

    // Shared request drive; sel picks which instance sees req_valid.
    logic        sel = 1'b0;
    logic        drv_valid = 1'b0;
    logic        drv_write = 1'b0;
    logic [1:0]  drv_size = 2'b00;
    logic        drv_unsigned = 1'b0;
    logic [31:0] drv_addr = 32'd0;
    logic [31:0] drv_wdata = 32'd0;

    assign bus_a.req_valid    = drv_valid & ~sel;
    assign bus_b.req_valid    = drv_valid & sel;
    assign bus_a.req_write    = drv_write;
    assign bus_b.req_write    = drv_write;
    assign bus_a.req_size     = drv_size;
    assign bus_b.req_size     = drv_size;
    assign bus_a.req_unsigned = drv_unsigned;
    assign bus_b.req_unsigned = drv_unsigned;
    assign bus_a.req_addr     = drv_addr;
    assign bus_b.req_addr     = drv_addr;
    assign bus_a.req_wdata    = drv_wdata;
    assign bus_b.req_wdata    = drv_wdata;

    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    assign bus_a.mem_read_data = mem_a[bus_a.mem_addr[3:0]];
    assign bus_b.mem_read_data = mem_b[bus_b.mem_addr[3:0]];
    always @(posedge clk) begin
        if (bus_a.mem_write_enable) mem_a[bus_a.mem_addr[3:0]] <= bus_a.mem_write_data;
        if (bus_b.mem_write_enable) mem_b[bus_b.mem_addr[3:0]] <= bus_b.mem_write_data;
    end

    int wr_cnt = 0;
    always @(posedge clk)
        wr_cnt <= wr_cnt + (bus_a.mem_write_enable ? 1 : 0) + (bus_b.mem_write_enable ? 1 : 0);

    logic        o_ready, o_resp_valid, o_resp_error;
    logic [31:0] o_resp_rdata, o_mem_addr;
    assign o_ready      = sel ? bus_b.req_ready  : bus_a.req_ready;
    assign o_resp_valid = sel ? bus_b.resp_valid : bus_a.resp_valid;
    assign o_resp_error = sel ? bus_b.resp_error : bus_a.resp_error;
    assign o_resp_rdata = sel ? bus_b.resp_rdata : bus_a.resp_rdata;
    assign o_mem_addr   = sel ? bus_b.mem_addr   : bus_a.mem_addr;

    // Reference: memory as plain bytes; byte address a lives at ref_mem[a mod 64].
    logic [7:0] ref_mem [2][64];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input bit s, input int w, input logic [31:0] v);
        if (s) mem_b[w] = v;
        else   mem_a[w] = v;
        for (int k = 0; k < 4; k++) ref_mem[s][w*4 + k] = v[8*k +: 8];
    endtask

    function automatic logic [31:0] ref_word(input bit s, input int w);
        logic [31:0] v;
        for (int k = 0; k < 4; k++) v[8*k +: 8] = ref_mem[s][w*4 + k];
        return v;
    endfunction

    task automatic check_mem(input bit s);
        for (int i = 0; i < 16; i++)
            check($sformatf("mem%0d_w%0d", s, i), s ? mem_b[i] : mem_a[i], ref_word(s, i));
    endtask

    task automatic run(input bit s, input bit w, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] wd);
        int          nb, lat, n, wr0;
        bit          spl, err;
        logic [31:0] exp_rd, mask, a0, a1;
        logic [5:0]  bi;
        nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        spl = (int'(a[1:0]) + nb) > 4;
        err = spl && s;
        lat = err ? 1 : (spl ? 3 : 2);
        exp_rd = 32'd0;
        if (!err) begin
            for (int k = 0; k < nb; k++) begin
                bi = a[5:0] + 6'(k);
                if (w) ref_mem[s][bi] = wd[8*k +: 8];
                else   exp_rd[8*k +: 8] = ref_mem[s][bi];
            end
            if (!w && nb < 4 && !u) begin
                mask = (32'd1 << (8*nb)) - 32'd1;
                if (exp_rd[8*nb-1]) exp_rd = exp_rd | ~mask;
            end
        end
        if (w || err) exp_rd = 32'd0;

        sel = s; drv_write = w; drv_size = sz; drv_unsigned = u; drv_addr = a; drv_wdata = wd;
        drv_valid = 1'b1;
        check("ready_before_accept", {31'd0, o_ready}, 32'd1);
        wr0 = wr_cnt;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        a0 = o_mem_addr;
        a1 = 32'd0;
        n  = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) a1 = o_mem_addr;
            if (o_resp_valid) begin
                n = i;
                break;
            end
        end
        check("latency", 32'(n), 32'(lat));
        check("resp_error", {31'd0, o_resp_error}, {31'd0, err});
        check("resp_rdata", o_resp_rdata, exp_rd);
        if (!err) check("mem_addr_first", a0, a >> 2);
        if (spl && !err) check("mem_addr_second", a1, (a + 32'd4) >> 2);
        check("write_count", 32'(wr_cnt - wr0), (err || !w) ? 32'd0 : (spl ? 32'd2 : 32'd1));
        @(posedge clk); #1;
        check("resp_pulse_low", {31'd0, o_resp_valid}, 32'd0);
        check("ready_after", {31'd0, o_ready}, 32'd1);
        check_mem(s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, rsp;
        logic [31:0] v, wd6;
        logic [1:0]  sz;

        for (int i = 0; i < 16; i++) begin
            poke(1'b0, i, $urandom);
            poke(1'b1, i, $urandom);
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", {30'd0, bus_a.resp_valid, bus_b.resp_valid}, 32'd0);
        check("rst_resp_error", {30'd0, bus_a.resp_error, bus_b.resp_error}, 32'd0);
        check("rst_rdata_a", bus_a.resp_rdata, 32'd0);
        check("rst_rdata_b", bus_b.resp_rdata, 32'd0);
        check("rst_ready", {30'd0, bus_a.req_ready, bus_b.req_ready}, 32'd3);
        check("rst_no_write", {30'd0, bus_a.mem_write_enable, bus_b.mem_write_enable}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Word store/load round trip
        run(1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'hDEADBEEF);
        check("t1_word1", mem_a[1], 32'hDEADBEEF);
        run(1'b0, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        check("t1_lw", o_resp_rdata, 32'hDEADBEEF);

        // Byte store and signed/unsigned byte loads
        run(1'b0, 1'b1, 2'b00, 1'b0, 32'h5, 32'h80);
        check("t2_word1", mem_a[1], 32'hDEAD80EF);
        run(1'b0, 1'b0, 2'b00, 1'b0, 32'h5, 32'h0);
        check("t2_lb", o_resp_rdata, 32'hFFFFFF80);
        run(1'b0, 1'b0, 2'b00, 1'b1, 32'h5, 32'h0);
        check("t2_lbu", o_resp_rdata, 32'h00000080);

        // Word-crossing load and half store
        poke(1'b0, 2, 32'h44332211);
        poke(1'b0, 3, 32'h88776655);
        run(1'b0, 1'b0, 2'b10, 1'b0, 32'hA, 32'h0);
        check("t3_lw_split", o_resp_rdata, 32'h66554433);
        run(1'b0, 1'b1, 2'b01, 1'b0, 32'hB, 32'hBEEF);
        check("t3_word2", mem_a[2], 32'hEF332211);
        check("t3_word3", mem_a[3], 32'h887766BE);

        // Rejected misaligned access on the non-splitting instance
        run(1'b1, 1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
        check("t4_error", {31'd0, o_resp_error}, 32'd1);
        run(1'b1, 1'b1, 2'b10, 1'b0, 32'h6, 32'h12345678);

        // Top-of-address-space split wraps to word 0
        run(1'b0, 1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0);
        run(1'b0, 1'b1, 2'b10, 1'b0, 32'hFFFFFFFD, $urandom);

        // Reset during the second word of a split store
        wd6 = $urandom;
        sel = 1'b0; drv_write = 1'b1; drv_size = 2'b10; drv_unsigned = 1'b0;
        drv_addr = 32'h6; drv_wdata = wd6; drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        acc = wr_cnt;
        @(posedge clk); #1;
        check("t6_in_w1_addr", o_mem_addr, 32'd2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t6_ready", {31'd0, o_ready}, 32'd1);
        check("t6_writes", 32'(wr_cnt - acc), 32'd1);
        ref_mem[0][6] = wd6[7:0];
        ref_mem[0][7] = wd6[15:8];
        rsp = 0;
        for (int i = 0; i < 4; i++) begin
            if (o_resp_valid) rsp++;
            @(posedge clk); #1;
        end
        check("t6_no_resp", 32'(rsp), 32'd0);
        check_mem(1'b0);

        // req_valid held high: one accept per IDLE visit
        sel = 1'b0; drv_write = 1'b0; drv_size = 2'b10; drv_unsigned = 1'b0;
        drv_addr = 32'h10; drv_valid = 1'b1;
        acc = 0; rsp = 0;
        for (int i = 0; i < 12; i++) begin
            if (o_ready) acc++;
            @(posedge clk); #1;
            if (o_resp_valid) rsp++;
        end
        drv_valid = 1'b0;
        check("t7_accepts", 32'(acc), 32'd4);
        check("t7_responses", 32'(rsp), 32'd4);
        check("t7_rdata", o_resp_rdata, ref_word(1'b0, 4));
        @(posedge clk); #1;

        // Randomized traffic on both instances
        for (int i = 0; i < 60; i++) begin
            sz = 2'($urandom_range(0, 3));
            v  = $urandom;
            run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                $urandom, v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
